id_operand_fwd: RTL and testbench
=================================

Name: id_operand_fwd

Overview:
- Parametrised operand-resolution and ID/EX issue stage for the pipelined core.
- Takes decoded fields from the decoder and regfile read data, and forwards from NUM_FWD downstream result sources with youngest-first priority.
- Detects not-yet-available (load-use) hazards and stalls.
- Resolves conditional-move write enables from forwarded data and holds the result in a valid/ready registered ID/EX slot.

Parameters:
- DATA_W, 32, operand/result width
- ADDR_W, 5, register address width
- NUM_FWD, 2, number of forwarding sources; index 0 youngest (EX), increasing = older (MEM, ...)
- CTRL_W, 11, opaque control passthrough width (aluop+alusel)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- flush_i  in  1  kill ID/EX slot contents
- in_valid_i  in  1  decoded instruction present
- in_ready_o  out  1  instruction accepted this cycle when in_valid_i also high
- reg1_read_i, reg2_read_i  in  1 each  operand uses register (else imm_i)
- reg1_addr_i, reg2_addr_i  in  ADDR_W each  source register addresses
- reg1_data_i, reg2_data_i  in  DATA_W each  regfile read data
- imm_i  in  DATA_W  extended immediate
- wd_i  in  ADDR_W  destination register
- wreg_i  in  1  instruction writes wd_i
- cond_i  in  2  00 unconditional, 01 write iff operand2!=0 (MOVN), 10 write iff operand2==0 (MOVZ), 11 reserved = unconditional
- ctrl_i  in  CTRL_W  control passthrough
- fwd_wreg_i  in  NUM_FWD  source i will write
- fwd_wd_i  in  NUM_FWD*ADDR_W  source i destination, slice i at [i*ADDR_W +: ADDR_W]
- fwd_wdata_i  in  NUM_FWD*DATA_W  source i data
- fwd_rdy_i  in  NUM_FWD  source i data valid this cycle (0 for a load not yet returned)
- out_valid_o  out  1  ID/EX slot occupied
- out_ready_i  in  1  EX consumes slot
- reg1_o, reg2_o  out  DATA_W each  resolved operands
- wd_o  out  ADDR_W  registered destination
- wreg_o  out  1  registered final write enable
- ctrl_o  out  CTRL_W  registered control passthrough
- stall_o  out  1  combinational hazard stall indicator

Behaviour:
- Operand n resolution, combinational:
  - read_n=0 -> imm_i.
  - addr_n=0 -> 0; never forwarded.
  - Otherwise the lowest index i with fwd_wreg_i[i] & fwd_wd_i[i]==addr_n supplies the operand: fwd_wdata_i[i] if fwd_rdy_i[i]=1, else hazard.
  - No match -> regfile data.
  - Older matches are ignored when a younger one exists, even if the younger is not ready.
- Hazard: stall_o = in_valid_i & (hazard on op1 | hazard on op2). stall_o is 0 when in_valid_i=0.
- Final write enable:
  - wreg_i=0 -> 0.
  - cond 01 -> resolved op2!=0.
  - cond 10 -> resolved op2==0.
  - Otherwise wreg_i.
- Handshake: in_ready_o = ~stall_o & (~out_valid_o | out_ready_i); accept = in_valid_i & in_ready_o.
- Register update, per rising edge:
  - flush_i -> out_valid_o<=0; other outputs are held. flush_i dominates and in_ready_o is forced 0 that cycle.
  - Else accept -> load all outputs; out_valid_o<=1.
  - Else out_valid_o & out_ready_i -> out_valid_o<=0.
  - Else hold.
- Latency: 1 cycle from accept to out_valid_o. Back-to-back throughput is 1/cycle.
- Output regs change only on accept; stable while out_valid_o & ~out_ready_i.
- Reset (rst=0, async): out_valid_o=0, reg1_o=reg2_o=0, wd_o=0, wreg_o=0, ctrl_o=0, stall counter=0. Reset mid-stall drops the held slot; the first accept after release behaves normally.

Optional Feature:
- Macro ID_STALL_CNT_EN.
- Defined: adds output stall_cnt_o (32 bits). It increments each cycle stall_o=1, saturates at 32'hFFFF_FFFF, clears on reset, and is unaffected by flush_i.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Plain issue: reg1_addr=3, regfile=0x11, no fwd match, imm_i=0x5, reg2_read=0 -> next cycle out_valid=1, reg1_o=0x11, reg2_o=0x5.
- Priority: both sources match addr 4; src0 data 0xAA rdy, src1 data 0xBB -> reg1_o=0xAA. Repeat with src0 rdy=0 -> stall_o=1, in_ready_o=0, no load, even though src1 is ready.
- Load-use: src0 matches addr 7, rdy=0 for 2 cycles then 1 with 0x1234 -> stall_o=1 for 2 cycles (counter=2 if ID_STALL_CNT_EN), then reg2_o=0x1234.
- Zero register: addr 0, src0 matches wd=0 with 0xFFFF_FFFF -> operand=0.
- MOVN/MOVZ: cond=01 with forwarded op2=0 -> wreg_o=0; cond=10 with op2=0 -> wreg_o=1; wreg_i=0 -> wreg_o=0.
- Backpressure/flush/reset:
  - out_ready_i=0 for 3 cycles -> outputs held, in_ready_o=0.
  - flush_i with in_valid_i=1 -> out_valid_o=0, no accept.
  - rst low mid-hold -> all outputs 0 immediately.

Source files
------------

// File: rtl/id_operand_fwd_if.sv
// id_operand_fwd_if: bundles the decoder/regfile inputs, forwarding buses and
// the ID/EX slot outputs of the id_operand_fwd stage.
//   slave  modport : used by id_operand_fwd (receives decode + fwd, drives slot)
//   master modport : used by the driving side (decoder / environment)
// Signal names keep the stage's original _i/_o names for drop-in compatibility.
interface id_operand_fwd_if #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NUM_FWD = 2,
  parameter int CTRL_W  = 11
);
  logic                        flush_i;
  logic                        in_valid_i;
  logic                        in_ready_o;
  logic                        reg1_read_i;
  logic                        reg2_read_i;
  logic [ADDR_W-1:0]           reg1_addr_i;
  logic [ADDR_W-1:0]           reg2_addr_i;
  logic [DATA_W-1:0]           reg1_data_i;
  logic [DATA_W-1:0]           reg2_data_i;
  logic [DATA_W-1:0]           imm_i;
  logic [ADDR_W-1:0]           wd_i;
  logic                        wreg_i;
  logic [1:0]                  cond_i;
  logic [CTRL_W-1:0]           ctrl_i;
  logic [NUM_FWD-1:0]          fwd_wreg_i;
  logic [NUM_FWD*ADDR_W-1:0]   fwd_wd_i;
  logic [NUM_FWD*DATA_W-1:0]   fwd_wdata_i;
  logic [NUM_FWD-1:0]          fwd_rdy_i;
  logic                        out_valid_o;
  logic                        out_ready_i;
  logic [DATA_W-1:0]           reg1_o;
  logic [DATA_W-1:0]           reg2_o;
  logic [ADDR_W-1:0]           wd_o;
  logic                        wreg_o;
  logic [CTRL_W-1:0]           ctrl_o;
  logic                        stall_o;

  modport slave (
    input  flush_i, in_valid_i, reg1_read_i, reg2_read_i, reg1_addr_i,
           reg2_addr_i, reg1_data_i, reg2_data_i, imm_i, wd_i, wreg_i,
           cond_i, ctrl_i, fwd_wreg_i, fwd_wd_i, fwd_wdata_i, fwd_rdy_i,
           out_ready_i,
    output in_ready_o, out_valid_o, reg1_o, reg2_o, wd_o, wreg_o, ctrl_o,
           stall_o
  );

  modport master (
    output flush_i, in_valid_i, reg1_read_i, reg2_read_i, reg1_addr_i,
           reg2_addr_i, reg1_data_i, reg2_data_i, imm_i, wd_i, wreg_i,
           cond_i, ctrl_i, fwd_wreg_i, fwd_wd_i, fwd_wdata_i, fwd_rdy_i,
           out_ready_i,
    input  in_ready_o, out_valid_o, reg1_o, reg2_o, wd_o, wreg_o, ctrl_o,
           stall_o
  );
endinterface

// File: rtl/id_operand_fwd.sv
// id_operand_fwd: operand resolution and ID/EX issue slot.
//   - Resolves both operands from immediate / zero register / forwarding
//     sources (index 0 youngest, wins) / regfile.
//   - Stalls when the youngest matching source has no data yet (load-use).
//   - Resolves MOVN/MOVZ write enables from the resolved operand 2.
//   - Holds the result in a valid/ready registered slot (1-cycle latency,
//     1/cycle throughput).
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   bus          id_operand_fwd_if.slave (decode inputs, fwd buses, slot outputs)
//   stall_cnt_o  saturating stall-cycle counter, present only when the
//                ID_STALL_CNT_EN macro is defined
module id_operand_fwd #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NUM_FWD = 2,
  parameter int CTRL_W  = 11
) (
  input  logic               clk,
  input  logic               rst,
  id_operand_fwd_if.slave    bus
`ifdef ID_STALL_CNT_EN
  ,
  output logic [31:0]        stall_cnt_o
`endif
);

  logic [DATA_W-1:0] op1;
  logic [DATA_W-1:0] op2;
  logic              hz1;
  logic              hz2;
  logic              hit1;
  logic              hit2;
  logic              wreg_final;
  logic              stall;
  logic              in_ready;
  logic              accept;

  logic              out_valid_q;
  logic [DATA_W-1:0] reg1_q;
  logic [DATA_W-1:0] reg2_q;
  logic [ADDR_W-1:0] wd_q;
  logic              wreg_q;
  logic [CTRL_W-1:0] ctrl_q;

  // Ascending scan with a hit flag: the first (youngest) match is latched and
  // older matches are ignored, even when the younger one is not ready.
  always_comb begin
    op1  = bus.reg1_data_i;
    op2  = bus.reg2_data_i;
    hz1  = 1'b0;
    hz2  = 1'b0;
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int unsigned i = 0; i < NUM_FWD; i++) begin
      if (!hit1 && bus.fwd_wreg_i[i] &&
          bus.fwd_wd_i[i*ADDR_W +: ADDR_W] == bus.reg1_addr_i) begin
        hit1 = 1'b1;
        hz1  = ~bus.fwd_rdy_i[i];
        op1  = bus.fwd_rdy_i[i] ? bus.fwd_wdata_i[i*DATA_W +: DATA_W]
                                : bus.reg1_data_i;
      end
      if (!hit2 && bus.fwd_wreg_i[i] &&
          bus.fwd_wd_i[i*ADDR_W +: ADDR_W] == bus.reg2_addr_i) begin
        hit2 = 1'b1;
        hz2  = ~bus.fwd_rdy_i[i];
        op2  = bus.fwd_rdy_i[i] ? bus.fwd_wdata_i[i*DATA_W +: DATA_W]
                                : bus.reg2_data_i;
      end
    end
    // Register 0 is hard-wired zero and never forwarded or stalled on.
    if (bus.reg1_addr_i == '0) begin
      op1 = '0;
      hz1 = 1'b0;
    end
    if (bus.reg2_addr_i == '0) begin
      op2 = '0;
      hz2 = 1'b0;
    end
    if (!bus.reg1_read_i) begin
      op1 = bus.imm_i;
      hz1 = 1'b0;
    end
    if (!bus.reg2_read_i) begin
      op2 = bus.imm_i;
      hz2 = 1'b0;
    end
  end

  always_comb begin
    wreg_final = bus.wreg_i;
    if (!bus.wreg_i)
      wreg_final = 1'b0;
    else if (bus.cond_i == 2'b01)
      wreg_final = (op2 != '0);
    else if (bus.cond_i == 2'b10)
      wreg_final = (op2 == '0);
  end

  assign stall    = bus.in_valid_i & (hz1 | hz2);
  // Flush wins over everything, so the slot never accepts in a flush cycle.
  assign in_ready = ~bus.flush_i & ~stall & (~out_valid_q | bus.out_ready_i);
  assign accept   = bus.in_valid_i & in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      reg1_q      <= '0;
      reg2_q      <= '0;
      wd_q        <= '0;
      wreg_q      <= 1'b0;
      ctrl_q      <= '0;
    end else if (bus.flush_i) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      reg1_q      <= op1;
      reg2_q      <= op2;
      wd_q        <= bus.wd_i;
      wreg_q      <= wreg_final;
      ctrl_q      <= bus.ctrl_i;
    end else if (out_valid_q && bus.out_ready_i) begin
      out_valid_q <= 1'b0;
    end
  end

`ifdef ID_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_cnt_q <= '0;
    else if (stall && stall_cnt_q != '1)
      stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

  assign bus.in_ready_o  = in_ready;
  assign bus.stall_o     = stall;
  assign bus.out_valid_o = out_valid_q;
  assign bus.reg1_o      = reg1_q;
  assign bus.reg2_o      = reg2_q;
  assign bus.wd_o        = wd_q;
  assign bus.wreg_o      = wreg_q;
  assign bus.ctrl_o      = ctrl_q;

endmodule

// File: tb/tb_id_operand_fwd.sv
// tb_id_operand_fwd: directed testbench for id_operand_fwd with hand-computed
// expected values. Inputs are driven 1 time unit after the rising edge,
// combinational outputs checked 1 unit later, registered outputs checked
// 1 unit after the following rising edge.
module tb_id_operand_fwd;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 5;
  localparam int NUM_FWD = 2;
  localparam int CTRL_W  = 11;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
`ifdef ID_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  id_operand_fwd_if #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NUM_FWD(NUM_FWD),
    .CTRL_W (CTRL_W)
  ) bus ();

  id_operand_fwd #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NUM_FWD(NUM_FWD),
    .CTRL_W (CTRL_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef ID_STALL_CNT_EN
    ,
    .stall_cnt_o(stall_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.flush_i     = 1'b0;
    bus.in_valid_i  = 1'b0;
    bus.reg1_read_i = 1'b0;
    bus.reg2_read_i = 1'b0;
    bus.reg1_addr_i = '0;
    bus.reg2_addr_i = '0;
    bus.reg1_data_i = '0;
    bus.reg2_data_i = '0;
    bus.imm_i       = '0;
    bus.wd_i        = '0;
    bus.wreg_i      = 1'b0;
    bus.cond_i      = 2'b00;
    bus.ctrl_i      = '0;
    bus.fwd_wreg_i  = '0;
    bus.fwd_wd_i    = '0;
    bus.fwd_wdata_i = '0;
    bus.fwd_rdy_i   = '0;
    bus.out_ready_i = 1'b1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b0;
    idle();
    #1;
    check("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
    check("rst_reg1", bus.reg1_o, 32'd0);
    check("rst_reg2", bus.reg2_o, 32'd0);
    check("rst_wd", 32'(bus.wd_o), 32'd0);
    check("rst_wreg", 32'(bus.wreg_o), 32'd0);
    check("rst_ctrl", 32'(bus.ctrl_o), 32'd0);
    check("rst_stall", 32'(bus.stall_o), 32'd0);
`ifdef ID_STALL_CNT_EN
    check("rst_cnt", stall_cnt, 32'd0);
`endif
    tick();
    tick();
    rst = 1'b1;

    // Plain issue: reg1 from regfile, reg2 from immediate.
    bus.in_valid_i  = 1'b1;
    bus.reg1_read_i = 1'b1;
    bus.reg1_addr_i = 5'd3;
    bus.reg1_data_i = 32'h11;
    bus.imm_i       = 32'h5;
    bus.wd_i        = 5'd9;
    bus.wreg_i      = 1'b1;
    bus.ctrl_i      = 11'h155;
    #1;
    check("plain_stall", 32'(bus.stall_o), 32'd0);
    check("plain_in_ready", 32'(bus.in_ready_o), 32'd1);
    tick();
    check("plain_valid", 32'(bus.out_valid_o), 32'd1);
    check("plain_reg1", bus.reg1_o, 32'h11);
    check("plain_reg2", bus.reg2_o, 32'h5);
    check("plain_wd", 32'(bus.wd_o), 32'd9);
    check("plain_wreg", 32'(bus.wreg_o), 32'd1);
    check("plain_ctrl", 32'(bus.ctrl_o), 32'h155);

    // Priority: both sources match r4, youngest wins.
    bus.reg1_addr_i = 5'd4;
    bus.reg1_data_i = 32'h99;
    bus.imm_i       = 32'h0;
    bus.wd_i        = 5'd10;
    bus.fwd_wreg_i  = 2'b11;
    bus.fwd_wd_i    = {5'd4, 5'd4};
    bus.fwd_wdata_i = {32'hBB, 32'hAA};
    bus.fwd_rdy_i   = 2'b11;
    #1;
    check("prio_stall", 32'(bus.stall_o), 32'd0);
    tick();
    check("prio_reg1", bus.reg1_o, 32'hAA);
    check("prio_wd", 32'(bus.wd_o), 32'd10);
    check("prio_valid", 32'(bus.out_valid_o), 32'd1);
    // Youngest not ready: stall even though the older source is ready.
    bus.fwd_rdy_i = 2'b10;
    #1;
    check("prio_nr_stall", 32'(bus.stall_o), 32'd1);
    check("prio_nr_in_ready", 32'(bus.in_ready_o), 32'd0);
    tick();
    check("prio_nr_valid", 32'(bus.out_valid_o), 32'd0);
    check("prio_nr_reg1_held", bus.reg1_o, 32'hAA);

    // Load-use on reg2 (r7): two stall cycles, then forwarded data.
    bus.reg1_read_i = 1'b0;
    bus.reg2_read_i = 1'b1;
    bus.reg2_addr_i = 5'd7;
    bus.reg2_data_i = 32'h55;
    bus.wd_i        = 5'd11;
    bus.fwd_wreg_i  = 2'b01;
    bus.fwd_wd_i    = {5'd0, 5'd7};
    bus.fwd_wdata_i = {32'h0, 32'h1234};
    bus.fwd_rdy_i   = 2'b00;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("lu_stall", 32'(bus.stall_o), 32'd1);
      check("lu_in_ready", 32'(bus.in_ready_o), 32'd0);
      tick();
      check("lu_valid", 32'(bus.out_valid_o), 32'd0);
    end
    bus.fwd_rdy_i = 2'b01;
    #1;
    check("lu_rdy_stall", 32'(bus.stall_o), 32'd0);
    check("lu_rdy_in_ready", 32'(bus.in_ready_o), 32'd1);
    tick();
    check("lu_valid_out", 32'(bus.out_valid_o), 32'd1);
    check("lu_reg2", bus.reg2_o, 32'h1234);
    check("lu_reg1_imm", bus.reg1_o, 32'h0);
`ifdef ID_STALL_CNT_EN
    // One stall cycle from the priority case plus two load-use cycles.
    check("lu_cnt", stall_cnt, 32'd3);
`endif

    // Zero register: never forwarded, never stalls on a pending r0 write.
    bus.reg1_read_i = 1'b1;
    bus.reg1_addr_i = 5'd0;
    bus.reg1_data_i = 32'h77;
    bus.reg2_read_i = 1'b0;
    bus.imm_i       = 32'h66;
    bus.fwd_wreg_i  = 2'b01;
    bus.fwd_wd_i    = {5'd0, 5'd0};
    bus.fwd_wdata_i = {32'h0, 32'hFFFF_FFFF};
    bus.fwd_rdy_i   = 2'b00;
    #1;
    check("zero_stall", 32'(bus.stall_o), 32'd0);
    tick();
    check("zero_reg1", bus.reg1_o, 32'h0);
    check("zero_reg2", bus.reg2_o, 32'h66);
    bus.fwd_rdy_i = 2'b01;
    tick();
    check("zero_reg1_rdy", bus.reg1_o, 32'h0);

    // MOVN / MOVZ on forwarded op2 (regfile value differs).
    bus.reg1_read_i = 1'b0;
    bus.reg2_read_i = 1'b1;
    bus.reg2_addr_i = 5'd5;
    bus.reg2_data_i = 32'h9;
    bus.fwd_wreg_i  = 2'b01;
    bus.fwd_wd_i    = {5'd0, 5'd5};
    bus.fwd_wdata_i = {32'h0, 32'h0};
    bus.fwd_rdy_i   = 2'b01;
    bus.wreg_i      = 1'b1;
    bus.cond_i      = 2'b01;
    tick();
    check("movn_zero_wreg", 32'(bus.wreg_o), 32'd0);
    check("movn_zero_reg2", bus.reg2_o, 32'h0);
    bus.cond_i = 2'b10;
    tick();
    check("movz_zero_wreg", 32'(bus.wreg_o), 32'd1);
    bus.cond_i      = 2'b01;
    bus.fwd_wdata_i = {32'h0, 32'h3};
    tick();
    check("movn_nz_wreg", 32'(bus.wreg_o), 32'd1);
    check("movn_nz_reg2", bus.reg2_o, 32'h3);
    bus.cond_i = 2'b10;
    tick();
    check("movz_nz_wreg", 32'(bus.wreg_o), 32'd0);
    bus.wreg_i      = 1'b0;
    bus.fwd_wdata_i = {32'h0, 32'h0};
    tick();
    check("nowreg_wreg", 32'(bus.wreg_o), 32'd0);
    bus.wreg_i = 1'b1;
    bus.cond_i = 2'b11;
    tick();
    check("cond11_wreg", 32'(bus.wreg_o), 32'd1);

    // Drain the slot before the backpressure sequence.
    bus.in_valid_i = 1'b0;
    tick();
    check("drain_valid", 32'(bus.out_valid_o), 32'd0);

    // Backpressure: load A, then hold for 3 cycles with B waiting.
    bus.in_valid_i  = 1'b1;
    bus.out_ready_i = 1'b0;
    bus.reg2_read_i = 1'b0;
    bus.fwd_wreg_i  = 2'b00;
    bus.imm_i       = 32'hA1;
    bus.wd_i        = 5'd12;
    bus.cond_i      = 2'b00;
    bus.ctrl_i      = 11'h0F0;
    #1;
    check("bp_a_in_ready", 32'(bus.in_ready_o), 32'd1);
    tick();
    check("bp_a_valid", 32'(bus.out_valid_o), 32'd1);
    check("bp_a_reg1", bus.reg1_o, 32'hA1);
    bus.imm_i  = 32'hB2;
    bus.wd_i   = 5'd13;
    bus.ctrl_i = 11'h2AA;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_in_ready", 32'(bus.in_ready_o), 32'd0);
      tick();
      check("bp_valid", 32'(bus.out_valid_o), 32'd1);
      check("bp_reg1_held", bus.reg1_o, 32'hA1);
      check("bp_wd_held", 32'(bus.wd_o), 32'd12);
    end

    // Flush with a valid instruction waiting: slot cleared, nothing loaded.
    bus.flush_i = 1'b1;
    #1;
    check("flush_in_ready", 32'(bus.in_ready_o), 32'd0);
    tick();
    check("flush_valid", 32'(bus.out_valid_o), 32'd0);
    check("flush_reg1_held", bus.reg1_o, 32'hA1);
    bus.flush_i = 1'b0;
    #1;
    check("post_flush_in_ready", 32'(bus.in_ready_o), 32'd1);
    tick();
    check("post_flush_valid", 32'(bus.out_valid_o), 32'd1);
    check("post_flush_reg1", bus.reg1_o, 32'hB2);
    check("post_flush_wd", 32'(bus.wd_o), 32'd13);

    // Reset while the slot is held.
    bus.in_valid_i = 1'b0;
    tick();
    check("hold_valid", 32'(bus.out_valid_o), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus.out_valid_o), 32'd0);
    check("mid_rst_reg1", bus.reg1_o, 32'd0);
    check("mid_rst_wd", 32'(bus.wd_o), 32'd0);
    check("mid_rst_wreg", 32'(bus.wreg_o), 32'd0);
    check("mid_rst_ctrl", 32'(bus.ctrl_o), 32'd0);
`ifdef ID_STALL_CNT_EN
    check("mid_rst_cnt", stall_cnt, 32'd0);
`endif
    tick();
    rst = 1'b1;
    bus.in_valid_i  = 1'b1;
    bus.out_ready_i = 1'b1;
    bus.imm_i       = 32'hC3;
    #1;
    check("after_rst_in_ready", 32'(bus.in_ready_o), 32'd1);
    tick();
    check("after_rst_valid", 32'(bus.out_valid_o), 32'd1);
    check("after_rst_reg1", bus.reg1_o, 32'hC3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
